// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the issue control pipeline.
//   - RV64 opcode constants recognised by the decoder
//   - ALUCTL_* ALU operation encodings (0 = no ALU operation)
//   - BRU_* branch unit encodings
//   - MDU_FUNCT7 marker for M-extension ops
//   - ctrl_lane_t: per-lane decoded control carried down the pipe
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [6:0] MDU_FUNCT7   = 7'b0000001;

    // Zero is reserved for "no ALU operation" so a cleared lane is unambiguous.
    localparam logic [4:0] ALUCTL_NONE = 5'd0;
    localparam logic [4:0] ALUCTL_ADD  = 5'd1;
    localparam logic [4:0] ALUCTL_SUB  = 5'd2;
    localparam logic [4:0] ALUCTL_SLL  = 5'd3;
    localparam logic [4:0] ALUCTL_SLT  = 5'd4;
    localparam logic [4:0] ALUCTL_SLTU = 5'd5;
    localparam logic [4:0] ALUCTL_XOR  = 5'd6;
    localparam logic [4:0] ALUCTL_SRL  = 5'd7;
    localparam logic [4:0] ALUCTL_SRA  = 5'd8;
    localparam logic [4:0] ALUCTL_OR   = 5'd9;
    localparam logic [4:0] ALUCTL_AND  = 5'd10;
    localparam logic [4:0] ALUCTL_LUI  = 5'd11;  // pass operand B
    localparam logic [4:0] ALUCTL_ADDW = 5'd12;
    localparam logic [4:0] ALUCTL_SUBW = 5'd13;
    localparam logic [4:0] ALUCTL_SLLW = 5'd14;
    localparam logic [4:0] ALUCTL_SRLW = 5'd15;
    localparam logic [4:0] ALUCTL_SRAW = 5'd16;

    localparam logic [3:0] BRU_NONE = 4'd0;
    localparam logic [3:0] BRU_JAL  = 4'd1;
    localparam logic [3:0] BRU_JALR = 4'd2;
    localparam logic [3:0] BRU_BEQ  = 4'd3;
    localparam logic [3:0] BRU_BNE  = 4'd4;
    localparam logic [3:0] BRU_BLT  = 4'd5;
    localparam logic [3:0] BRU_BGE  = 4'd6;
    localparam logic [3:0] BRU_BLTU = 4'd7;
    localparam logic [3:0] BRU_BGEU = 4'd8;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       alusrc;
        logic       alusrc_pc;
        logic [4:0] aluctl;
        logic [3:0] bruop;
        logic [3:0] mductl;    // {is_word, funct3}
        logic       memread;
        logic       memwrite;
        logic [2:0] rw_type;
        logic       regwrite;
    } ctrl_lane_t;

endpackage

// File: rtl/lane_decode.sv
// lane_decode: combinational decoder for one issue lane.
// Ports:
//   i_valid  - slot holds a real instruction
//   i_opcode - 7-bit opcode, i_func3 - funct3, i_func7 - funct7
//   o_ctrl   - decoded control; all-zero when i_valid is low
// Lane placement: M-ext ops are legal only when LANE==MDU_LANE, loads and
// stores only when LANE==LSU_LANE. An illegal lane keeps valid=1 and
// illegal=1 with every other control field cleared.
module lane_decode
    import ctrl_pkg::*;
#(
    parameter int LANE     = 0,
    parameter int MDU_LANE = 0,
    parameter int LSU_LANE = 0
) (
    input  logic       i_valid,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output ctrl_lane_t o_ctrl
);

    localparam logic IS_MDU_LANE = (LANE == MDU_LANE);
    localparam logic IS_LSU_LANE = (LANE == LSU_LANE);

    ctrl_lane_t w_dec;
    logic       w_bad;
    logic [4:0] w_alu_base;

    // funct3 -> ALU op shared by OP and OP-IMM; bit 30 selects arithmetic shift.
    always_comb begin
        case (i_func3)
            3'b000:  w_alu_base = ALUCTL_ADD;
            3'b001:  w_alu_base = ALUCTL_SLL;
            3'b010:  w_alu_base = ALUCTL_SLT;
            3'b011:  w_alu_base = ALUCTL_SLTU;
            3'b100:  w_alu_base = ALUCTL_XOR;
            3'b101:  w_alu_base = i_func7[5] ? ALUCTL_SRA : ALUCTL_SRL;
            3'b110:  w_alu_base = ALUCTL_OR;
            default: w_alu_base = ALUCTL_AND;
        endcase
    end

    always_comb begin
        w_dec = '0;
        w_bad = 1'b0;
        case (i_opcode)
            OPC_LUI: begin
                w_dec.alusrc   = 1'b1;
                w_dec.aluctl   = ALUCTL_LUI;
                w_dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.alusrc    = 1'b1;
                w_dec.alusrc_pc = 1'b1;
                w_dec.aluctl    = ALUCTL_ADD;
                w_dec.regwrite  = 1'b1;
            end
            OPC_JAL: begin
                w_dec.alusrc    = 1'b1;
                w_dec.alusrc_pc = 1'b1;
                w_dec.aluctl    = ALUCTL_ADD;
                w_dec.bruop     = BRU_JAL;
                w_dec.regwrite  = 1'b1;
            end
            OPC_JALR: begin
                w_dec.alusrc   = 1'b1;
                w_dec.aluctl   = ALUCTL_ADD;
                w_dec.bruop    = BRU_JALR;
                w_dec.regwrite = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.aluctl = ALUCTL_SUB;
                case (i_func3)
                    3'b000:  w_dec.bruop = BRU_BEQ;
                    3'b001:  w_dec.bruop = BRU_BNE;
                    3'b100:  w_dec.bruop = BRU_BLT;
                    3'b101:  w_dec.bruop = BRU_BGE;
                    3'b110:  w_dec.bruop = BRU_BLTU;
                    3'b111:  w_dec.bruop = BRU_BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_bad          = !IS_LSU_LANE;
                w_dec.alusrc   = 1'b1;
                w_dec.aluctl   = ALUCTL_ADD;
                w_dec.memread  = 1'b1;
                w_dec.rw_type  = i_func3;
                w_dec.regwrite = 1'b1;
            end
            OPC_STORE: begin
                w_bad          = !IS_LSU_LANE;
                w_dec.alusrc   = 1'b1;
                w_dec.aluctl   = ALUCTL_ADD;
                w_dec.memwrite = 1'b1;
                w_dec.rw_type  = i_func3;
            end
            OPC_OP_IMM: begin
                w_dec.alusrc   = 1'b1;
                w_dec.aluctl   = w_alu_base;
                w_dec.regwrite = 1'b1;
            end
            OPC_OP: begin
                w_dec.regwrite = 1'b1;
                if (i_func7 == MDU_FUNCT7) begin
                    w_bad        = !IS_MDU_LANE;
                    w_dec.mductl = {1'b0, i_func3};
                end else if (i_func3 == 3'b000 && i_func7[5]) begin
                    w_dec.aluctl = ALUCTL_SUB;
                end else begin
                    w_dec.aluctl = w_alu_base;
                end
            end
            OPC_OP_IMM32: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                case (i_func3)
                    3'b000:  w_dec.aluctl = ALUCTL_ADDW;
                    3'b001:  w_dec.aluctl = ALUCTL_SLLW;
                    3'b101:  w_dec.aluctl = i_func7[5] ? ALUCTL_SRAW : ALUCTL_SRLW;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_OP32: begin
                w_dec.regwrite = 1'b1;
                if (i_func7 == MDU_FUNCT7) begin
                    w_bad        = !IS_MDU_LANE;
                    w_dec.mductl = {1'b1, i_func3};
                end else begin
                    case (i_func3)
                        3'b000:  w_dec.aluctl = i_func7[5] ? ALUCTL_SUBW : ALUCTL_ADDW;
                        3'b001:  w_dec.aluctl = ALUCTL_SLLW;
                        3'b101:  w_dec.aluctl = i_func7[5] ? ALUCTL_SRAW : ALUCTL_SRLW;
                        default: w_bad = 1'b1;
                    endcase
                end
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Valid gates everything; an illegal lane keeps only valid and illegal.
    always_comb begin
        o_ctrl = '0;
        if (i_valid) begin
            if (!w_bad) o_ctrl = w_dec;
            o_ctrl.valid   = 1'b1;
            o_ctrl.illegal = w_bad;
        end
    end

endmodule

// File: rtl/issue_ctrl_pipe.sv
// issue_ctrl_pipe: N-wide decode-to-writeback control pipeline.
// Decodes ISSUE_NUM slots in D (lane_decode per lane) and carries the
// control through E, M and W registers.
// Ports:
//   clk, rst_n (async, active low)
//   validD/opcodeD/func3D/func7D - per-lane decode-stage inputs
//   stallE (hold E, bubble into M), flushE, flushM
//   validE/M/W, alusrcE, alusrc_pcE, aluctlE, mductlE, bruopE, illegalE
//   memreadM, memwriteM, RW_typeM (LSU_LANE), regwriteM, regwriteW
// Optional macro CTRL_PERF_CNT_EN adds retired_cnt and bubble_cnt (64-bit).
module issue_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ISSUE_NUM = 4,
    parameter int MDU_LANE  = ISSUE_NUM - 1,
    parameter int LSU_LANE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ISSUE_NUM-1:0]   validD,
    input  logic [7*ISSUE_NUM-1:0] opcodeD,
    input  logic [3*ISSUE_NUM-1:0] func3D,
    input  logic [7*ISSUE_NUM-1:0] func7D,
    input  logic                   stallE,
    input  logic                   flushE,
    input  logic                   flushM,
    output logic [ISSUE_NUM-1:0]   validE,
    output logic [ISSUE_NUM-1:0]   validM,
    output logic [ISSUE_NUM-1:0]   validW,
    output logic [ISSUE_NUM-1:0]   alusrcE,
    output logic [ISSUE_NUM-1:0]   alusrc_pcE,
    output logic [5*ISSUE_NUM-1:0] aluctlE,
    output logic [3:0]             mductlE,
    output logic [4*ISSUE_NUM-1:0] bruopE,
    output logic                   memreadM,
    output logic                   memwriteM,
    output logic [2:0]             RW_typeM,
    output logic [ISSUE_NUM-1:0]   regwriteM,
    output logic [ISSUE_NUM-1:0]   regwriteW,
    output logic [ISSUE_NUM-1:0]   illegalE
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [63:0]            retired_cnt,
    output logic [63:0]            bubble_cnt
`endif
);

    ctrl_lane_t w_dec [ISSUE_NUM];
    ctrl_lane_t r_e   [ISSUE_NUM];
    ctrl_lane_t r_m   [ISSUE_NUM];
    logic [ISSUE_NUM-1:0] r_validW;
    logic [ISSUE_NUM-1:0] r_regwriteW;

    for (genvar g = 0; g < ISSUE_NUM; g++) begin : g_lane
        lane_decode #(
            .LANE     (g),
            .MDU_LANE (MDU_LANE),
            .LSU_LANE (LSU_LANE)
        ) u_dec (
            .i_valid  (validD[g]),
            .i_opcode (opcodeD[7*g +: 7]),
            .i_func3  (func3D[3*g +: 3]),
            .i_func7  (func7D[7*g +: 7]),
            .o_ctrl   (w_dec[g])
        );
    end

    // flush outranks stall in both stages; a stall holds E and bubbles M.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ISSUE_NUM; i++) begin
                r_e[i] <= '0;
                r_m[i] <= '0;
            end
            r_validW    <= '0;
            r_regwriteW <= '0;
        end else begin
            for (int i = 0; i < ISSUE_NUM; i++) begin
                if (flushE)       r_e[i] <= '0;
                else if (!stallE) r_e[i] <= w_dec[i];

                if (flushM || stallE) r_m[i] <= '0;
                else                  r_m[i] <= r_e[i];

                r_validW[i]    <= r_m[i].valid;
                r_regwriteW[i] <= r_m[i].regwrite;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_NUM; i++) begin
            validE[i]          = r_e[i].valid;
            alusrcE[i]         = r_e[i].alusrc;
            alusrc_pcE[i]      = r_e[i].alusrc_pc;
            aluctlE[5*i +: 5]  = r_e[i].aluctl;
            bruopE[4*i +: 4]   = r_e[i].bruop;
            illegalE[i]        = r_e[i].illegal;
            validM[i]          = r_m[i].valid;
            regwriteM[i]       = r_m[i].regwrite;
        end
        mductlE   = r_e[MDU_LANE].mductl;
        memreadM  = r_m[LSU_LANE].memread;
        memwriteM = r_m[LSU_LANE].memwrite;
        RW_typeM  = r_m[LSU_LANE].rw_type;
    end

    assign validW    = r_validW;
    assign regwriteW = r_regwriteW;

    // Fields that only matter on the dedicated MDU/LSU lanes are still
    // stored per lane; fold them here so they are visibly consumed.
    logic w_unused_fields;
    always_comb begin
        w_unused_fields = 1'b0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            w_unused_fields = w_unused_fields ^ (^r_e[i]) ^ (^r_m[i]);
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [ISSUE_NUM-1:0] r_illegalW;
    logic [63:0]          r_retired_cnt;
    logic [63:0]          r_bubble_cnt;
    logic [63:0]          w_retire_inc;

    always_comb begin
        w_retire_inc = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            w_retire_inc = w_retire_inc + 64'(r_validW[i] & ~r_illegalW[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegalW    <= '0;
            r_retired_cnt <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            for (int i = 0; i < ISSUE_NUM; i++) r_illegalW[i] <= r_m[i].illegal;
            r_retired_cnt <= r_retired_cnt + w_retire_inc;
            r_bubble_cnt  <= r_bubble_cnt + 64'(stallE | flushE);
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign bubble_cnt  = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_issue_ctrl_pipe.sv
// tb_issue_ctrl_pipe: directed + random stimulus against a reference model
// of the issue control pipeline (ISSUE_NUM=4, MDU lane 3, LSU lane 0).
module tb_issue_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int N = 4;
    localparam int MDU_L = 3;
    localparam int LSU_L = 0;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   validD;
    logic [7*N-1:0] opcodeD;
    logic [3*N-1:0] func3D;
    logic [7*N-1:0] func7D;
    logic           stallE, flushE, flushM;
    logic [N-1:0]   validE, validM, validW, alusrcE, alusrc_pcE;
    logic [5*N-1:0] aluctlE;
    logic [3:0]     mductlE;
    logic [4*N-1:0] bruopE;
    logic           memreadM, memwriteM;
    logic [2:0]     RW_typeM;
    logic [N-1:0]   regwriteM, regwriteW, illegalE;
`ifdef CTRL_PERF_CNT_EN
    logic [63:0]    retired_cnt, bubble_cnt;
    logic [63:0]    exp_ret, exp_bub;
`endif

    issue_ctrl_pipe #(.ISSUE_NUM(N)) dut (
        .clk(clk), .rst_n(rst_n), .validD(validD), .opcodeD(opcodeD),
        .func3D(func3D), .func7D(func7D), .stallE(stallE), .flushE(flushE),
        .flushM(flushM), .validE(validE), .validM(validM), .validW(validW),
        .alusrcE(alusrcE), .alusrc_pcE(alusrc_pcE), .aluctlE(aluctlE),
        .mductlE(mductlE), .bruopE(bruopE), .memreadM(memreadM),
        .memwriteM(memwriteM), .RW_typeM(RW_typeM), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .illegalE(illegalE)
`ifdef CTRL_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- stimulus lanes ----------------
    logic       t_v   [N];
    logic [6:0] t_opc [N];
    logic [2:0] t_f3  [N];
    logic [6:0] t_f7  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            validD[i]          = t_v[i];
            opcodeD[7*i +: 7]  = t_opc[i];
            func3D[3*i +: 3]   = t_f3[i];
            func7D[7*i +: 7]   = t_f7[i];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v, ill, src, srcpc;
        logic [4:0] alu;
        logic [3:0] bru, mdu;
        logic       mr, mw;
        logic [2:0] rw;
        logic       rwr;
    } exp_lane_t;

    exp_lane_t me [N];
    exp_lane_t mm [N];
    exp_lane_t mw [N];

    int n_checks = 0;
    int n_err    = 0;

    function automatic exp_lane_t ref_dec(int lane, logic v, logic [6:0] opc,
                                          logic [2:0] f3, logic [6:0] f7);
        exp_lane_t r;
        logic [4:0] op_tab [8];
        logic [3:0] br_tab [8];
        logic bad;
        op_tab = '{ALUCTL_ADD, ALUCTL_SLL, ALUCTL_SLT, ALUCTL_SLTU,
                   ALUCTL_XOR, ALUCTL_SRL, ALUCTL_OR, ALUCTL_AND};
        br_tab = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8};
        r = '0;
        bad = 1'b0;
        if (!v) return r;
        if (opc == 7'b0110111) begin            // LUI
            r.src = 1; r.alu = ALUCTL_LUI; r.rwr = 1;
        end else if (opc == 7'b0010111) begin   // AUIPC
            r.src = 1; r.srcpc = 1; r.alu = ALUCTL_ADD; r.rwr = 1;
        end else if (opc == 7'b1101111) begin   // JAL
            r.src = 1; r.srcpc = 1; r.alu = ALUCTL_ADD; r.bru = 4'd1; r.rwr = 1;
        end else if (opc == 7'b1100111) begin   // JALR
            r.src = 1; r.alu = ALUCTL_ADD; r.bru = 4'd2; r.rwr = 1;
        end else if (opc == 7'b1100011) begin   // BRANCH
            r.alu = ALUCTL_SUB; r.bru = br_tab[f3]; bad = (br_tab[f3] == 4'd0);
        end else if (opc == 7'b0000011) begin   // LOAD
            r.src = 1; r.alu = ALUCTL_ADD; r.mr = 1; r.rw = f3; r.rwr = 1;
            bad = (lane != LSU_L);
        end else if (opc == 7'b0100011) begin   // STORE
            r.src = 1; r.alu = ALUCTL_ADD; r.mw = 1; r.rw = f3;
            bad = (lane != LSU_L);
        end else if (opc == 7'b0010011) begin   // OP-IMM
            r.src = 1; r.rwr = 1;
            r.alu = (f3 == 3'd5 && f7[5]) ? ALUCTL_SRA : op_tab[f3];
        end else if (opc == 7'b0110011) begin   // OP
            r.rwr = 1;
            if (f7 == 7'b0000001) begin
                r.mdu = {1'b0, f3}; bad = (lane != MDU_L);
            end else if (f7[5] && f3 == 3'd0) r.alu = ALUCTL_SUB;
            else if (f7[5] && f3 == 3'd5)     r.alu = ALUCTL_SRA;
            else                              r.alu = op_tab[f3];
        end else if (opc == 7'b0011011 || opc == 7'b0111011) begin // *-32
            r.rwr = 1;
            r.src = (opc == 7'b0011011);
            if (opc == 7'b0111011 && f7 == 7'b0000001) begin
                r.mdu = {1'b1, f3}; bad = (lane != MDU_L);
            end else if (f3 == 3'd0)
                r.alu = (opc == 7'b0111011 && f7[5]) ? ALUCTL_SUBW : ALUCTL_ADDW;
            else if (f3 == 3'd1) r.alu = ALUCTL_SLLW;
            else if (f3 == 3'd5) r.alu = f7[5] ? ALUCTL_SRAW : ALUCTL_SRLW;
            else bad = 1;
        end else begin
            bad = 1;
        end
        if (bad) begin
            r = '0; r.ill = 1;
        end
        r.v = 1;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0]   e_v, e_m, e_w, e_src, e_pc, e_rm, e_rw, e_ill;
        logic [5*N-1:0] e_alu;
        logic [4*N-1:0] e_bru;
        for (int l = 0; l < N; l++) begin
            e_v[l] = me[l].v;  e_src[l] = me[l].src; e_pc[l] = me[l].srcpc;
            e_ill[l] = me[l].ill; e_alu[5*l +: 5] = me[l].alu;
            e_bru[4*l +: 4] = me[l].bru;
            e_m[l] = mm[l].v;  e_rm[l] = mm[l].rwr;
            e_w[l] = mw[l].v;  e_rw[l] = mw[l].rwr;
        end
        chk("validE", 64'(validE), 64'(e_v));
        chk("validM", 64'(validM), 64'(e_m));
        chk("validW", 64'(validW), 64'(e_w));
        chk("alusrcE", 64'(alusrcE), 64'(e_src));
        chk("alusrc_pcE", 64'(alusrc_pcE), 64'(e_pc));
        chk("aluctlE", 64'(aluctlE), 64'(e_alu));
        chk("bruopE", 64'(bruopE), 64'(e_bru));
        chk("illegalE", 64'(illegalE), 64'(e_ill));
        chk("mductlE", 64'(mductlE), 64'(me[MDU_L].mdu));
        chk("memreadM", 64'(memreadM), 64'(mm[LSU_L].mr));
        chk("memwriteM", 64'(memwriteM), 64'(mm[LSU_L].mw));
        chk("RW_typeM", 64'(RW_typeM), 64'(mm[LSU_L].rw));
        chk("regwriteM", 64'(regwriteM), 64'(e_rm));
        chk("regwriteW", 64'(regwriteW), 64'(e_rw));
`ifdef CTRL_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, exp_ret);
        chk("bubble_cnt", bubble_cnt, exp_bub);
`endif
    endtask

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            me[l] = '0; mm[l] = '0; mw[l] = '0;
        end
`ifdef CTRL_PERF_CNT_EN
        exp_ret = '0; exp_bub = '0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_lanes();
        for (int l = 0; l < N; l++) begin
            t_v[l] = 0; t_opc[l] = '0; t_f3[l] = '0; t_f7[l] = '0;
        end
    endtask

    task automatic set_lane(input int l, input logic [6:0] opc,
                            input logic [2:0] f3, input logic [6:0] f7);
        t_v[l] = 1; t_opc[l] = opc; t_f3[l] = f3; t_f7[l] = f7;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare every output just after the edge.
    task automatic step();
        @(posedge clk);
`ifdef CTRL_PERF_CNT_EN
        for (int l = 0; l < N; l++) exp_ret += 64'(mw[l].v & ~mw[l].ill);
        exp_bub += 64'(stallE | flushE);
`endif
        for (int l = 0; l < N; l++) begin
            mw[l] = mm[l];
            mm[l] = (flushM || stallE) ? exp_lane_t'('0) : me[l];
            if (flushE)       me[l] = '0;
            else if (!stallE) me[l] = ref_dec(l, t_v[l], t_opc[l], t_f3[l], t_f7[l]);
        end
        #1;
        check_all();
    endtask

    task automatic drive_random();
        logic [6:0] opc_list [11];
        logic [6:0] f7_list [3];
        int k;
        opc_list = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                     7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                     7'b0111011};
        f7_list = '{7'b0000000, 7'b0100000, 7'b0000001};
        for (int l = 0; l < N; l++) begin
            t_v[l] = ($urandom_range(0, 4) != 0);
            k = $urandom_range(0, 11);
            t_opc[l] = (k == 11) ? 7'($urandom) : opc_list[k];
            t_f3[l] = 3'($urandom);
            k = $urandom_range(0, 3);
            t_f7[l] = (k == 3) ? 7'($urandom) : f7_list[k];
        end
        stallE = ($urandom_range(0, 5) == 0);
        flushE = ($urandom_range(0, 9) == 0);
        flushM = ($urandom_range(0, 9) == 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 0; stallE = 0; flushE = 0; flushM = 0;
        clear_lanes();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();                                   // reset state
        @(negedge clk);
        rst_n = 1;

        // ADD lane 0, BEQ lane 1; then LW lane 0
        set_lane(0, 7'b0110011, 3'b000, 7'b0000000);
        set_lane(1, 7'b1100011, 3'b000, 7'b0000000);
        step();
        chk("tp_add_aluctlE0", 64'(aluctlE[4:0]), 64'(ALUCTL_ADD));
        chk("tp_beq_bruopE1", 64'(bruopE[7:4]), 64'd3);
        clear_lanes();
        set_lane(0, 7'b0000011, 3'b010, 7'b0000000);
        step();
        chk("tp_add_regwriteM0", 64'(regwriteM[0]), 64'd1);
        clear_lanes();
        step();
        chk("tp_lw_memreadM", 64'(memreadM), 64'd1);
        chk("tp_lw_RW_typeM", 64'(RW_typeM), 64'd2);

        // MUL on lane 3 (legal) then on lane 1 (illegal)
        set_lane(3, 7'b0110011, 3'b000, 7'b0000001);
        step();
        chk("tp_mul_mductlE", 64'(mductlE), 64'd0);
        chk("tp_mul_illegalE3", 64'(illegalE[3]), 64'd0);
        clear_lanes();
        set_lane(1, 7'b0110011, 3'b000, 7'b0000001);
        step();
        chk("tp_mul1_illegalE1", 64'(illegalE[1]), 64'd1);
        clear_lanes();
        step();
        chk("tp_mul1_regwriteM1", 64'(regwriteM[1]), 64'd0);

        // SW in E, stall two cycles, then release
        set_lane(0, 7'b0100011, 3'b011, 7'b0000000);
        step();
        clear_lanes();
        set_lane(2, 7'b0010011, 3'b000, 7'b0000000);
        stallE = 1;
        step();
        chk("tp_stall_memwriteM_1", 64'(memwriteM), 64'd0);
        step();
        chk("tp_stall_memwriteM_2", 64'(memwriteM), 64'd0);
        chk("tp_stall_heldE", 64'(validE), 64'd1);
        stallE = 0;
        clear_lanes();
        step();
        chk("tp_stall_release_memwriteM", 64'(memwriteM), 64'd1);

        // both stages full, then flushE+flushM together (with a stall too)
        for (int l = 0; l < N; l++) set_lane(l, 7'b0010011, 3'b110, 7'b0000000);
        step();
        step();
        flushE = 1; flushM = 1; stallE = 1;
        step();
        chk("tp_flush_validE", 64'(validE), 64'd0);
        chk("tp_flush_validM", 64'(validM), 64'd0);
        chk("tp_flush_validW", 64'(validW), 64'hF);
        flushE = 0; flushM = 0; stallE = 0;
        clear_lanes();

        // undefined opcode on lane 2
        set_lane(2, 7'b1111111, 3'b000, 7'b0000000);
        step();
        chk("tp_undef_illegalE2", 64'(illegalE[2]), 64'd1);
        chk("tp_undef_aluctlE2", 64'(aluctlE[14:10]), 64'd0);
        clear_lanes();
        repeat (3) step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive_random();
            step();
        end
        stallE = 0; flushE = 0; flushM = 0;

        // asynchronous reset mid-stream with every lane valid
        for (int l = 0; l < N; l++) set_lane(l, 7'b0110111, 3'b000, 7'b0000000);
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("tp_rst_validW", 64'(validW), 64'd0);
        @(negedge clk);
        rst_n = 1;
        clear_lanes();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_ctrl_pipe.md
Name: issue_ctrl_pipe

Overview:
- Parametrised control pipeline for the N-wide RV64IM in-order core.
- Each cycle it decodes ISSUE_NUM instruction slots in the decode stage into ALU, MDU, BRU and LSU control.
- Decoded control is carried through the E/M/W pipeline registers with a per-lane valid bit, stall and stage-selective flush.
- Sits between the decode/regfile-read stage and the execute, memory and writeback datapath; it supersedes the fixed 4-lane control block.

Parameters:
- ISSUE_NUM, 4, number of issue lanes (1..8).
- MDU_LANE, ISSUE_NUM-1, index of the lane allowed to issue mul/div; M-ext on any other lane is flagged illegal.
- LSU_LANE, 0, index of the lane allowed to issue load/store; memory ops on any other lane are flagged illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- validD  in  ISSUE_NUM  slot holds a real instruction.
- opcodeD  in  7*ISSUE_NUM  opcode per lane.
- func3D  in  3*ISSUE_NUM  funct3 per lane.
- func7D  in  7*ISSUE_NUM  funct7 per lane.
- stallE  in  1  hold the E register; insert a bubble into M.
- flushE  in  1  clear all E lanes.
- flushM  in  1  clear all M lanes.
- validE/validM/validW  out  ISSUE_NUM each  per-stage lane valid.
- alusrcE, alusrc_pcE  out  ISSUE_NUM each  ALU operand selects.
- aluctlE  out  5*ISSUE_NUM  ALU operation.
- mductlE  out  4  MDU operation for MDU_LANE: {is_word, funct3}.
- bruopE  out  4*ISSUE_NUM  0 none, 1 jal, 2 jalr, 3 beq, 4 bne, 5 blt, 6 bge, 7 bltu, 8 bgeu.
- memreadM, memwriteM  out  1 each  LSU_LANE memory strobes.
- RW_typeM  out  3  LSU_LANE funct3.
- regwriteM, regwriteW  out  ISSUE_NUM each  register write enable.
- illegalE  out  ISSUE_NUM  undecodable or wrong-lane instruction.

Behaviour:
- Decode is combinational in D.
- Recognised opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
- OP/OP-32 with funct7=0000001 is an MDU op; legal only on MDU_LANE.
- LOAD/STORE are legal only on LSU_LANE.
- Any other opcode, or a wrong-lane op, sets illegal and forces regwrite, memread, memwrite, bruop and the MDU strobe to 0 for that lane. The lane's valid bit is kept.
- All control outputs are gated by valid: an invalid lane carries all-zero control.
- E register, priority on each clock edge:
  - flushE: all E fields cleared, validE=0.
  - else stallE: E holds its contents.
  - else E takes the D decode.
- M register, priority on each clock edge:
  - flushM: all M fields cleared.
  - else stallE: M loads a bubble (all zero).
  - else M takes E.
- W register always takes M.
- Latency: D to E is 1 cycle, to M 2 cycles, to W 3 cycles.
- Both flushes active in the same cycle: both stages are cleared, and stallE is ignored.
- Reset: every output, valid and control bit is 0 asynchronously. The first valid instruction appears in E one cycle after rst_n deasserts plus one edge. Reset asserted mid-operation discards all in-flight lanes immediately.
- ISSUE_NUM=1: MDU_LANE=LSU_LANE=0 is legal.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds outputs retired_cnt (64) and bubble_cnt (64).
  - retired_cnt increments each cycle by the popcount of validW & ~illegalW, using an internal W copy of illegal.
  - bubble_cnt increments by 1 for each cycle stallE=1 or flushE=1.
  - Both counters reset to 0 and wrap modulo 2^64.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - the ALUCTL_* 5-bit encodings;
  - the BRU_* 4-bit encodings;
  - MDU_FUNCT7=7'b0000001;
  - the ctrl_lane_t struct (valid, illegal, alusrc, alusrc_pc, aluctl, bruop, mductl, memread, memwrite, rw_type, regwrite).
- One sub-module, lane_decode: a combinational per-lane decoder with lane-index parameters, instantiated ISSUE_NUM times in a generate loop.
- Pipeline registers stay in the top level.

Test Plan:
- ADD on lane 0, BEQ on lane 1, LW (funct3=010) on lane 0 the next cycle → cycle 1: aluctlE[0]=ALUCTL_ADD, bruopE[1]=3. Cycle 2: regwriteM[0]=1. LW → memreadM=1, RW_typeM=3'b010 two cycles after issue.
- MUL (OP, funct7=0000001, funct3=000) on lane 3 → mductlE=4'b0000, illegalE[3]=0. The same op on lane 1 → illegalE[1]=1, regwriteM[1]=0.
- stallE high for 2 cycles with SW in E → E held both cycles, memwriteM=0 during the stall, memwriteM=1 once the stall drops.
- flushE and flushM together with valid lanes in both stages → next cycle validE=0 and validM=0, while validW still reflects the old M contents.
- Opcode 7'b1111111 on lane 2 → illegalE[2]=1 and all control zero. With CTRL_PERF_CNT_EN, retired_cnt does not count it.
- rst_n pulled low mid-stream with all lanes valid → all outputs 0 immediately (asynchronous reset); with CTRL_PERF_CNT_EN the counters read 0.
